// File: rtl/i2c_byte_master.sv
// i2c_byte_master: byte-level I2C master behind the sensor controllers'
// ena / data_wr / data_rd / busy / new_byte handshake. Single master, 7-bit
// addressing, no clock stretching. Drives open-drain pads via scl_oe/sda_oe
// (1 = pull low). Every bit cell has four quarters of CLK_DIV clocks:
// p0/p1 SCL low (SDA changes on p0 entry), p2/p3 SCL released, SDA sampled
// on entry to p3. new_byte is the one-cycle "byte finished" pulse.
module i2c_byte_master #(
   parameter int CLK_DIV = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [6:0] addr,
   input  logic       rw,
   input  logic [7:0] data_wr,
   output logic [7:0] data_rd,
   output logic       busy,
   output logic       new_byte,
   output logic       ack_error,
   output logic       scl_oe,
   output logic       sda_oe,
   input  logic       sda_in
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MACK, STOP
   } state_t;

   localparam logic [11:0] Q_LAST = 12'(CLK_DIV - 1);

   state_t      state;
   logic [11:0] q_cnt;
   logic [1:0]  phase;
   logic [2:0]  bit_cnt;
   logic [6:0]  cur_addr;
   logic        cur_rw;
   logic [7:0]  cur_data;
   logic [7:0]  tx_shift;
   logic [7:0]  rx_shift;
   logic        ack_bit;      // slave ACK level sampled in the last ack slot
   logic        cont;         // ena seen at the decision point
   logic        same_target;  // {addr,rw} unchanged at the decision point
   logic        stop_free;    // second STOP cell: bus-free time

   logic q_wrap;
   logic cell_end;
   logic same_now;

   assign q_wrap   = (q_cnt == Q_LAST);
   assign cell_end = q_wrap && (phase == 2'd3);
   assign same_now = ({addr, rw} == {cur_addr, cur_rw});

   // Single FSM: quarter ticker, bit cells, pad drive and handshake outputs.
   always_ff @(posedge clk) begin
      // NOTE: reset is synchronous and checked first; a reset mid-transfer
      // releases both lines on the next cycle without generating a STOP.
      if (rst) begin
         state       <= IDLE;
         q_cnt       <= '0;
         phase       <= '0;
         bit_cnt     <= 3'd7;
         cur_addr    <= '0;
         cur_rw      <= 1'b0;
         cur_data    <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         ack_bit     <= 1'b0;
         cont        <= 1'b0;
         same_target <= 1'b0;
         stop_free   <= 1'b0;
         data_rd     <= '0;
         busy        <= 1'b0;
         new_byte    <= 1'b0;
         ack_error   <= 1'b0;
         scl_oe      <= 1'b0;
         sda_oe      <= 1'b0;
      end else begin
         // NOTE: every state update uses non-blocking assignment so all
         // decisions below see the values from the start of this cycle.
         new_byte <= 1'b0;
         if (state == IDLE) begin
            q_cnt <= '0;
            phase <= '0;
            if (ena) begin
               cur_addr  <= addr;
               cur_rw    <= rw;
               cur_data  <= data_wr;
               busy      <= 1'b1;
               ack_error <= 1'b0;
               state     <= START;
               scl_oe    <= 1'b0;
               sda_oe    <= 1'b0;
            end
         end else begin
            q_cnt <= q_wrap ? '0 : q_cnt + 12'd1;
            if (q_wrap)
               phase <= phase + 2'd1;

            // Entering p2: release SCL.
            if (q_wrap && phase == 2'd1)
               scl_oe <= 1'b0;

            // Entering p3: START/STOP edges on SDA, and the sample point.
            if (q_wrap && phase == 2'd2) begin
               case (state)
                  START: sda_oe <= 1'b1;
                  STOP:  if (!stop_free) sda_oe <= 1'b0;
                  ADDR_ACK, WRITE_ACK: begin
                     ack_bit <= sda_in;
                     if (sda_in)
                        ack_error <= 1'b1;
                  end
                  READ: begin
                     rx_shift <= {rx_shift[6:0], sda_in};
                     if (bit_cnt == 3'd0) begin
                        data_rd  <= {rx_shift[6:0], sda_in};
                        new_byte <= 1'b1;
                     end
                  end
                  WRITE: if (bit_cnt == 3'd0) new_byte <= 1'b1;
                  default: ;
               endcase
            end

            // End of bit cell: choose the next cell and set p0 pad levels.
            if (cell_end) begin
               scl_oe <= 1'b1;
               case (state)
                  START: begin
                     state    <= ADDR;
                     bit_cnt  <= 3'd7;
                     tx_shift <= {cur_addr, cur_rw};
                     sda_oe   <= ~cur_addr[6];
                  end
                  ADDR, WRITE: begin
                     if (bit_cnt != 3'd0) begin
                        bit_cnt  <= bit_cnt - 3'd1;
                        tx_shift <= tx_shift << 1;
                        sda_oe   <= ~tx_shift[6];
                     end else begin
                        sda_oe <= 1'b0;
                        if (state == ADDR) begin
                           state <= ADDR_ACK;
                        end else begin
                           // Decision point: take the follow-up request.
                           state       <= WRITE_ACK;
                           cont        <= ena;
                           same_target <= same_now;
                           cur_addr    <= addr;
                           cur_rw      <= rw;
                           cur_data    <= data_wr;
                        end
                     end
                  end
                  READ: begin
                     if (bit_cnt != 3'd0) begin
                        bit_cnt <= bit_cnt - 3'd1;
                        sda_oe  <= 1'b0;
                     end else begin
                        // Decision point: master ACKs only a same-target follow-up.
                        state       <= MACK;
                        sda_oe      <= ena && same_now;
                        cont        <= ena;
                        same_target <= same_now;
                        cur_addr    <= addr;
                        cur_rw      <= rw;
                        cur_data    <= data_wr;
                     end
                  end
                  ADDR_ACK, WRITE_ACK, MACK: begin
                     if ((state != MACK && ack_bit) || (state != ADDR_ACK && !cont)) begin
                        state     <= STOP;
                        stop_free <= 1'b0;
                        sda_oe    <= 1'b1;
                     end else if (state == ADDR_ACK || same_target) begin
                        bit_cnt <= 3'd7;
                        if (cur_rw) begin
                           state  <= READ;
                           sda_oe <= 1'b0;
                        end else begin
                           state    <= WRITE;
                           tx_shift <= cur_data;
                           sda_oe   <= ~cur_data[7];
                        end
                     end else begin
                        state  <= START;
                        sda_oe <= 1'b0;
                     end
                  end
                  STOP: begin
                     scl_oe <= 1'b0;
                     sda_oe <= 1'b0;
                     if (!stop_free) begin
                        stop_free <= 1'b1;
                     end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                     end
                  end
                  default: state <= IDLE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_byte_master.sv
// Testbench for i2c_byte_master at CLK_DIV=4: a bus-level slave model at
// address 0x68 logs START/STOP and every byte with its ACK bit; directed
// table vectors plus multi-byte, repeated-START, NACK and reset sequences.
module tb_i2c_byte_master;

   localparam int CLK_DIV = 4;
   localparam int CELL = 4 * CLK_DIV;
   localparam logic [6:0] SLV = 7'h68;
   localparam int EV_START = 32'h1000;
   localparam int EV_STOP  = 32'h2000;

   logic       clk = 1'b0;
   logic       rst;
   logic       ena;
   logic [6:0] addr;
   logic       rw;
   logic [7:0] data_wr;
   logic [7:0] data_rd;
   logic       busy;
   logic       new_byte;
   logic       ack_error;
   logic       scl_oe;
   logic       sda_oe;
   logic       sda_in;
   logic       scl;
   logic       s_drv = 1'b0;

   assign scl    = ~scl_oe;
   assign sda_in = ~sda_oe & ~s_drv;

   i2c_byte_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk(clk), .rst(rst), .ena(ena), .addr(addr), .rw(rw),
      .data_wr(data_wr), .data_rd(data_rd), .busy(busy), .new_byte(new_byte),
      .ack_error(ack_error), .scl_oe(scl_oe), .sda_oe(sda_oe), .sda_in(sda_in)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc++;

   // ---------------- monitor ----------------
   int busy_cnt = 0;
   int new_cnt = 0;
   int new_rd[$];
   int new_t[$];

   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (new_byte === 1'b1) begin
         new_cnt++;
         new_rd.push_back(int'(data_rd));
         new_t.push_back(cyc);
      end
   end

   // ---------------- slave model ----------------
   typedef enum {S_IDLE, S_ADDR, S_WRITE, S_READ} sph_t;
   sph_t       s_ph = S_IDLE;
   int         s_bit = 0;
   logic [7:0] s_byte = '0;
   logic [7:0] s_tx = '0;
   logic       s_acked = 1'b0;
   logic       scl_q = 1'b1;
   logic       sda_q = 1'b1;
   int         scl_last = 0;
   int         scl_gap = 0;
   int         ev[$];
   logic [7:0] rd_q[$];

   always @(negedge clk) begin
      int  nb;
      logic sda_now;
      sda_now = ~sda_oe & ~s_drv;
      if (!scl_q && scl === 1'b1) begin
         scl_gap  = cyc - scl_last;
         scl_last = cyc;
      end
      if (scl_q && scl === 1'b1 && sda_q && sda_now === 1'b0) begin
         ev.push_back(EV_START);
         s_ph = S_ADDR; s_bit = -1; s_drv = 1'b0;
      end else if (scl_q && scl === 1'b1 && !sda_q && sda_now === 1'b1) begin
         ev.push_back(EV_STOP);
         s_ph = S_IDLE; s_drv = 1'b0;
      end else if (s_ph != S_IDLE && !scl_q && scl === 1'b1) begin
         if (s_bit >= 0 && s_bit < 8) begin
            s_byte = {s_byte[6:0], sda_now};
         end else if (s_bit == 8) begin
            ev.push_back({23'd0, sda_now, s_byte});
            s_acked = !sda_now;
         end
      end else if (s_ph != S_IDLE && scl_q && scl === 1'b0) begin
         nb = s_bit + 1;
         if (nb == 9) begin
            nb = 0;
            case (s_ph)
               S_ADDR:  s_ph = !s_acked ? S_IDLE : (s_byte[0] ? S_READ : S_WRITE);
               S_READ:  if (!s_acked) s_ph = S_IDLE;
               default: ;
            endcase
         end
         s_bit = nb;
         s_drv = 1'b0;
         if (s_ph == S_READ && nb < 8) begin
            if (nb == 0) s_tx = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hFF;
            s_drv = ~s_tx[7 - nb];
         end else if (nb == 8 && (s_ph == S_WRITE || (s_ph == S_ADDR && s_byte[7:1] == SLV))) begin
            s_drv = 1'b1;
         end
      end
      scl_q = (scl === 1'b1);
      sda_q = ~sda_oe & ~s_drv;
   end

   // ---------------- helpers ----------------
   int exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      busy_cnt = 0; new_cnt = 0;
      new_rd.delete(); new_t.delete(); ev.delete();
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      check({name, "_idle"}, int'(busy), 0);
   endtask

   task automatic wait_new(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while (new_byte !== 1'b1 && n < budget) begin @(negedge clk); n++; end
      check({name, "_new"}, int'(new_byte), 1);
   endtask

   task automatic check_log(input string name);
      check({name, "_len"}, ev.size(), exp_q.size());
      for (int k = 0; k < exp_q.size() && k < ev.size(); k++)
         check($sformatf("%s_ev%0d", name, k), ev[k], exp_q[k]);
   endtask

   task automatic request(input logic [6:0] a, input logic r, input logic [7:0] d);
      ena = 1'b1; addr = a; rw = r; data_wr = d;
      @(negedge clk);
      check("busy_after_accept", int'(busy), 1);
   endtask

   // ---------------- vectors ----------------
   typedef struct {
      logic [6:0] addr;
      logic       rw;
      logic [7:0] wdata;
      logic [7:0] sbyte;
      int         exp_addr;
      int         exp_data;
   } vec_t;

   vec_t vecs[4];

   initial begin
      vecs[0] = '{7'h68, 1'b0, 8'h6B, 8'h00, 'h0D0, 'h06B};
      vecs[1] = '{7'h68, 1'b0, 8'hA5, 8'h00, 'h0D0, 'h0A5};
      vecs[2] = '{7'h68, 1'b1, 8'h00, 8'h5A, 'h0D1, 'h15A};
      vecs[3] = '{7'h68, 1'b1, 8'h00, 8'h81, 'h0D1, 'h181};

      rst = 1'b1; ena = 1'b0; addr = '0; rw = 1'b0; data_wr = '0;
      repeat (3) @(negedge clk);
      check("rst_scl_oe", int'(scl_oe), 0);
      check("rst_sda_oe", int'(sda_oe), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_new", int'(new_byte), 0);
      check("rst_ack_error", int'(ack_error), 0);
      check("rst_data_rd", int'(data_rd), 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Single-byte transactions with an ena pulse.
      for (int i = 0; i < 4; i++) begin
         clear_mon();
         rd_q.delete();
         rd_q.push_back(vecs[i].sbyte);
         request(vecs[i].addr, vecs[i].rw, vecs[i].wdata);
         ena = 1'b0;
         wait_idle($sformatf("v%0d", i), 2000);
         check($sformatf("v%0d_new_cnt", i), new_cnt, 1);
         check($sformatf("v%0d_busy_cycles", i), busy_cnt, 21 * CELL);
         check($sformatf("v%0d_ack_error", i), int'(ack_error), 0);
         if (vecs[i].rw && new_rd.size() > 0)
            check($sformatf("v%0d_data_rd", i), new_rd[0], int'(vecs[i].sbyte));
         exp_q = {EV_START, vecs[i].exp_addr, vecs[i].exp_data, EV_STOP};
         check_log($sformatf("v%0d_bus", i));
         repeat (3) @(negedge clk);
      end

      // Two-byte read: master ACKs byte 1, NACKs byte 2.
      clear_mon();
      rd_q = {8'h12, 8'h34};
      request(7'h68, 1'b1, 8'h00);
      wait_new("rd1", 2000);
      check("rd1_data", int'(data_rd), 'h12);
      wait_new("rd2", 2000);
      ena = 1'b0;
      check("rd2_data", int'(data_rd), 'h34);
      wait_idle("rd", 2000);
      check("rd_new_cnt", new_cnt, 2);
      check("rd_busy_cycles", busy_cnt, 30 * CELL);
      exp_q = {EV_START, 'h0D1, 'h012, 'h134, EV_STOP};
      check_log("rd_bus");
      repeat (3) @(negedge clk);

      // Register read: write 0x1D, then repeated START for a read.
      clear_mon();
      rd_q = {8'hA7};
      request(7'h68, 1'b0, 8'h1D);
      wait_new("rr_wr", 2000);
      rw = 1'b1;
      wait_new("rr_rd", 3000);
      ena = 1'b0;
      check("rr_data", int'(data_rd), 'hA7);
      wait_idle("rr", 2000);
      check("rr_new_cnt", new_cnt, 2);
      check("rr_busy_cycles", busy_cnt, 40 * CELL);
      exp_q = {EV_START, 'h0D0, 'h01D, EV_START, 'h0D1, 'h1A7, EV_STOP};
      check_log("rr_bus");
      repeat (3) @(negedge clk);

      // Address NACK with ena held high.
      clear_mon();
      begin
         int n = 0;
         request(7'h50, 1'b0, 8'h00);
         while (ack_error !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
         check("nack_flag", int'(ack_error), 1);
      end
      ena = 1'b0;
      wait_idle("nack", 1000);
      check("nack_new_cnt", new_cnt, 0);
      check("nack_sticky", int'(ack_error), 1);
      check("nack_busy_cycles", busy_cnt, 12 * CELL);
      exp_q = {EV_START, 'h1A0, EV_STOP};
      check_log("nack_bus");
      repeat (3) @(negedge clk);
      clear_mon();
      request(7'h68, 1'b0, 8'h55);
      check("nack_cleared", int'(ack_error), 0);
      ena = 1'b0;
      wait_idle("after_nack", 2000);
      exp_q = {EV_START, 'h0D0, 'h055, EV_STOP};
      check_log("after_nack_bus");
      repeat (3) @(negedge clk);

      // Reset during bit 4 of a WRITE byte (0x6B bit 4 = 0: SDA low, SCL low in p1).
      clear_mon();
      request(7'h68, 1'b0, 8'h6B);
      ena = 1'b0;
      repeat (13 * CELL + 7) @(negedge clk);
      check("pre_rst_scl_oe", int'(scl_oe), 1);
      check("pre_rst_sda_oe", int'(sda_oe), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_rst_scl_oe", int'(scl_oe), 0);
      check("mid_rst_sda_oe", int'(sda_oe), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_data_rd", int'(data_rd), 0);
      repeat (4) @(negedge clk);
      clear_mon();
      request(7'h68, 1'b0, 8'h3C);
      ena = 1'b0;
      wait_idle("post_rst", 2000);
      check("post_rst_new_cnt", new_cnt, 1);
      exp_q = {EV_START, 'h0D0, 'h03C, EV_STOP};
      check_log("post_rst_bus");
      repeat (3) @(negedge clk);

      // Back-to-back writes with ena held, data incremented at each new pulse.
      clear_mon();
      request(7'h68, 1'b0, 8'h40);
      wait_new("b2b1", 2000);
      data_wr = 8'h41;
      wait_new("b2b2", 2000);
      data_wr = 8'h42;
      wait_new("b2b3", 2000);
      ena = 1'b0;
      wait_idle("b2b", 2000);
      check("b2b_new_cnt", new_cnt, 3);
      check("b2b_busy_cycles", busy_cnt, 39 * CELL);
      check("b2b_scl_period", scl_gap, CELL);
      if (new_t.size() == 3) begin
         check("b2b_gap1", new_t[1] - new_t[0], 9 * CELL);
         check("b2b_gap2", new_t[2] - new_t[1], 9 * CELL);
      end
      exp_q = {EV_START, 'h0D0, 'h040, 'h041, 'h042, EV_STOP};
      check_log("b2b_bus");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_byte_master.md
Name: i2c_byte_master

Overview:
- Byte-level I2C master: the bus-side engine behind the gyro controller's `ena`/`data_wr`/`data_rd`/`busy`/`new` handshake.
- Accepts a 7-bit address, direction and write byte; generates START, repeated START and STOP; shifts bytes; reports slave ACK status.
- Sits between the sensor controllers and the open-drain SCL/SDA pads.
- Single master, 7-bit addressing, no clock stretching, no arbitration.

Parameters:
- CLK_DIV, 250: clk cycles per quarter SCL period (bit time = 4*CLK_DIV; 100 MHz -> 100 kHz). Legal range 4..4095.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  request/continue transaction
- addr  in  7  slave address
- rw  in  1  1=read, 0=write
- data_wr  in  8  byte to write
- data_rd  out  8  last byte read
- busy  out  1  transaction in progress
- new  out  1  one-cycle pulse: byte finished, next request window open
- ack_error  out  1  sticky slave NACK flag
- scl_oe  out  1  1 = pull SCL low, 0 = release
- sda_oe  out  1  1 = pull SDA low, 0 = release
- sda_in  in  1  sampled SDA pad level

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE, scl_oe=0, sda_oe=0, busy=0, new=0, ack_error=0, data_rd=0x00, quarter counter=0, bit counter=7. Reset mid-transfer aborts immediately; both lines are released the next cycle, with no STOP generated.
- Quarter ticker: a counter runs 0..CLK_DIV-1 and advances phase p0..p3 on wrap. Counter and phase are held at 0 in IDLE.
- Bit cell phases:
  - p0/p1: SCL low; SDA is updated at p0 entry.
  - p2/p3: SCL released.
  - SDA is sampled on the first cycle of p3.
- States: IDLE, START, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, MACK, STOP.
- IDLE:
  - ena=1 at a posedge latches addr, rw, data_wr.
  - busy=1 from the next cycle; ack_error cleared; go to START.
  - ena=0 keeps the bus released.
- START (also used for repeated START):
  - p0/p1: SDA released, SCL low (repeated START only).
  - p2: SCL released.
  - p3: SDA pulled low.
  - Then SCL low and go to ADDR.
- ADDR: shift {addr,rw} MSB first, 8 bit cells, then ADDR_ACK.
- ADDR_ACK: SDA released; sda_in sampled at p3.
  - 0 -> WRITE (rw=0) or READ (rw=1).
  - 1 -> ack_error=1, go to STOP.
- WRITE: shift the latched data_wr MSB first, then WRITE_ACK.
- WRITE_ACK: sample as in ADDR_ACK; NACK -> ack_error=1, STOP.
- READ:
  - Shift in 8 bits, MSB first, SDA released.
  - After the 8th sample, data_rd is updated and new=1 in that same cycle (first cycle of bit-0 p3).
- new for writes: asserted one cycle on the first cycle of bit-0 p3 of a WRITE byte.
- Request window: from the new pulse to the end of bit-0 p3 (CLK_DIV-1 cycles). The controller must present the next ena/addr/rw/data_wr inside this window.
- Decision point D: last cycle of bit-0 p3. The master latches ena, addr, rw, data_wr.
- MACK (read): drive SDA low (ACK) iff at D ena=1 and {addr,rw} equal to the current {addr,rw}; otherwise release (NACK).
- After the ack slot of a completed data byte, using values latched at D (NACK from the slave overrides to STOP):
  - ena=0 -> STOP.
  - ena=1, same {addr,rw} -> next WRITE/READ byte, no START.
  - ena=1, different {addr,rw} -> repeated START.
- STOP:
  - p0/p1: SDA low, SCL low.
  - p2: SCL released.
  - p3: SDA released.
  - Then one full bit time of bus-free; then IDLE with busy=0.
- busy=1 from the cycle after acceptance through the last bus-free cycle. busy never drops between chained bytes.
- No new pulse for address bytes.
- ack_error stays set until the next IDLE acceptance.
- ena changes outside IDLE or the request window are ignored.

Test Plan:
- CLK_DIV=4, ena pulse, addr=0x68, rw=0, data_wr=0x6B, ena dropped after new -> bus shows START, 0xD0 ACK, 0x6B ACK, STOP; busy high 1 cycle after ena, low after STOP+bus-free; exactly one new pulse; ack_error=0.
- Read of 2 bytes from 0x68; slave returns 0x12, 0x34; ena held through first window, dropped in second -> data_rd=0x12 at first new, 0x34 at second; master ACK after byte 1, NACK after byte 2, then STOP.
- Register read: write 0x1D to 0x68, then in the window set rw=1 with ena=1 -> repeated START (SDA falls while SCL high, no STOP between), address byte 0xD1, read byte returned on data_rd.
- Slave NACKs address 0x50 with ena held high -> ack_error=1, STOP issued, no new pulse, busy falls. The next accepted request clears ack_error.
- Assert rst during bit 4 of a WRITE -> the next cycle shows scl_oe=0, sda_oe=0, busy=0, state IDLE. A subsequent request completes normally.
- ena=1 held continuously with addr=0x68, rw=0, data_wr incrementing at each new -> back-to-back write bytes with no START between; bit cell exactly 16 cycles at CLK_DIV=4.
